// File: rtl/tt_um_falcon.sv
// Modular arithmetic unit over the Falcon prime field: add, subtract, multiply and reduce
// 14-bit operands mod Q, loaded and started through a byte-wide strobed command port.
module tt_um_falcon #(
    parameter int unsigned Q = 12289
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [15:0] QW  = 16'(Q);
    localparam logic [15:0] Q2W = 16'(2 * Q);

    localparam logic [2:0] CmdLdALo = 3'd1;
    localparam logic [2:0] CmdLdAHi = 3'd2;
    localparam logic [2:0] CmdLdBLo = 3'd3;
    localparam logic [2:0] CmdLdBHi = 3'd4;
    localparam logic [2:0] CmdStart = 3'd5;
    localparam logic [2:0] CmdSel   = 3'd6;

    localparam logic [1:0] OpAdd = 2'd0;
    localparam logic [1:0] OpSub = 2'd1;
    localparam logic [1:0] OpMul = 2'd2;
    localparam logic [1:0] OpRed = 2'd3;

    // Counter value on the final busy cycle: latency minus one.
    localparam logic [4:0] LastShort = 5'd1;
    localparam logic [4:0] LastMul   = 5'd15;
    localparam logic [4:0] MulSteps  = 5'd14;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [13:0] a_q, a_d;
    logic [13:0] b_q, b_d;
    logic [13:0] r_q, r_d;
    logic [1:0]  op_q, op_d;
    logic        sel_q, sel_d;
    logic        done_q, done_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [13:0] acc_q, acc_d;
    logic [13:0] mcand_q, mcand_d;
    logic [13:0] mplier_q, mplier_d;

    logic        wr_en;
    logic [2:0]  cmd;
    logic        start;
    logic        last;
    logic        busy;
    logic [15:0] a_red;
    logic [15:0] b_red;
    logic [15:0] sum_red;
    logic [15:0] diff_red;
    logic [15:0] step_raw;
    logic [15:0] step_red;
    logic [15:0] result;
    logic        unused_bits;

    function automatic logic [15:0] red1(input logic [15:0] x);
        return (x >= QW) ? x - QW : x;
    endfunction

    assign wr_en = uio_in[0];
    assign cmd   = uio_in[3:1];
    assign start = wr_en && (cmd == CmdStart) && (state_q == StIdle);
    assign last  = (cnt_q == ((op_q == OpMul) ? LastMul : LastShort));

    // Operands span 0..16383 < 2Q, so one conditional subtract brings them into range.
    always_comb begin
        a_red    = red1({2'b00, a_q});
        b_red    = red1({2'b00, b_q});
        sum_red  = red1(a_red + b_red);
        diff_red = (a_red >= b_red) ? (a_red - b_red) : (a_red + QW - b_red);
    end

    // MSB-first shift-add step: 2*acc + mcand < 3Q, so at most 2Q must be removed.
    always_comb begin
        step_raw = {1'b0, acc_q, 1'b0} + (mplier_q[13] ? {2'b00, mcand_q} : 16'd0);
        step_red = (step_raw >= Q2W) ? (step_raw - Q2W) : red1(step_raw);
    end

    always_comb begin
        unique case (op_q)
            OpAdd:   result = sum_red;
            OpSub:   result = diff_red;
            OpMul:   result = {2'b00, acc_q};
            OpRed:   result = a_red;
            default: result = 16'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy:  if (last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            op_q     <= '0;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        op_d     = op_q;
        sel_d    = sel_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (state_q == StIdle) begin
            if (wr_en) begin
                case (cmd)
                    CmdLdALo: a_d[7:0]  = ui_in;
                    CmdLdAHi: a_d[13:8] = ui_in[5:0];
                    CmdLdBLo: b_d[7:0]  = ui_in;
                    CmdLdBHi: b_d[13:8] = ui_in[5:0];
                    CmdStart: begin
                        op_d     = ui_in[1:0];
                        done_d   = 1'b0;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = a_red[13:0];
                        mplier_d = b_q;
                    end
                    CmdSel:   sel_d = ui_in[0];
                    default:  ;
                endcase
            end
        end else begin
            cnt_d = cnt_q + 5'd1;
            if ((op_q == OpMul) && (cnt_q < MulSteps)) begin
                acc_d    = step_red[13:0];
                mplier_d = {mplier_q[12:0], 1'b0};
            end
            if (last) begin
                done_d = 1'b1;
                r_d    = result[13:0];
            end
        end
    end

    // Outputs
    always_comb begin
        busy    = (state_q == StBusy);
        uo_out  = sel_q ? {2'b00, r_q[13:8]} : r_q[7:0];
        uio_out = {1'b0, (r_q == '0), done_q, busy, 4'b0000};
        uio_oe  = 8'hF0;
    end

    assign unused_bits = ^{ena, uio_in[7:4], a_red[15:14], b_red[15:14], sum_red[15:14],
                           diff_red[15:14], step_red[15:14], result[15:14]};

endmodule

// File: tb/tb_tt_um_falcon.sv
// Self-checking bench for tt_um_falcon: directed vector table, random operations against a
// plain-arithmetic model, and hand-written reset/abort sequences.
module tb_tt_um_falcon;

    localparam int Q = 12289;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    tt_um_falcon #(.Q(Q)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int op;
        int exp_r;
        int exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int cmd, input int data);
        uio_in = {4'b0000, 3'(cmd), 1'b1};
        ui_in  = 8'(data);
        tick();
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic load(input int a, input int b);
        wr(1, a & 8'hFF);
        wr(2, (a >> 8) & 8'h3F);
        wr(3, b & 8'hFF);
        wr(4, (b >> 8) & 8'h3F);
    endtask

    function automatic int model(input int a, input int b, input int op);
        longint p;
        case (op)
            0: return (a + b) % Q;
            1: return (((a - b) % Q) + Q) % Q;
            2: begin
                p = longint'(a) * longint'(b);
                return int'(p % Q);
            end
            default: return a % Q;
        endcase
    endfunction

    // Starts op, measures busy length, and checks result bytes, flags and hold behaviour.
    task automatic run_op(input string name, input int op, input int exp_r, input int exp_lat,
                          input bit poke);
        int  lat;
        int  prev;
        bit  held;
        prev   = uo_out;
        held   = 1'b1;
        wr(5, op);
        chk({name, ".busy_at_start"}, int'(uio_out[4]), 1);
        chk({name, ".done_cleared"}, int'(uio_out[5]), 0);
        lat = 0;
        while (uio_out[4] && lat < 40) begin
            if (int'(uo_out) != prev) held = 1'b0;
            if (poke) begin
                uio_in = {4'b0000, 3'($urandom_range(1, 6)), 1'b1};
                ui_in  = 8'($urandom);
            end
            lat++;
            tick();
        end
        uio_in = 8'h00;
        ui_in  = 8'h00;
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".r_held"}, int'(held), 1);
        chk({name, ".r_lo"}, int'(uo_out), exp_r & 8'hFF);
        chk({name, ".uio_out"}, int'(uio_out), (exp_r == 0) ? 8'h60 : 8'h20);
        wr(6, 1);
        chk({name, ".r_hi"}, int'(uo_out), (exp_r >> 8) & 8'h3F);
        wr(6, 0);
    endtask

    initial begin
        int a;
        int b;
        int op;
        int er;
        checks = 0;
        errors = 0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b1;

        vecs[0] = '{a: 12288, b: 5,     op: 0, exp_r: 4,     exp_lat: 2};
        vecs[1] = '{a: 3,     b: 10,    op: 1, exp_r: 12282, exp_lat: 2};
        vecs[2] = '{a: 1234,  b: 5678,  op: 2, exp_r: 1922,  exp_lat: 16};
        vecs[3] = '{a: 12288, b: 12288, op: 2, exp_r: 1,     exp_lat: 16};
        vecs[4] = '{a: 16383, b: 0,     op: 3, exp_r: 4094,  exp_lat: 2};
        vecs[5] = '{a: 16383, b: 16383, op: 1, exp_r: 0,     exp_lat: 2};
        vecs[6] = '{a: 16383, b: 16383, op: 2, exp_r: 10929, exp_lat: 16};
        vecs[7] = '{a: 100,   b: 12289, op: 0, exp_r: 100,   exp_lat: 2};

        tick();
        tick();
        chk("reset.uo_out", int'(uo_out), 8'h00);
        chk("reset.uio_out", int'(uio_out), 8'h40);
        chk("reset.uio_oe", int'(uio_oe), 8'hF0);
        rst_n = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            load(vecs[i].a, vecs[i].b);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].exp_r, vecs[i].exp_lat,
                   (i == 2));
        end

        // Strobes during the poked mul must not have changed the operands.
        load(1234, 5678);
        run_op("mul_poked", 2, 1922, 16, 1'b1);
        run_op("after_poke_add", 0, (1234 + 5678) % Q, 2, 1'b0);

        for (int i = 0; i < 30; i++) begin
            a  = int'($urandom_range(0, 16383));
            b  = int'($urandom_range(0, 16383));
            op = int'($urandom_range(0, 3));
            er = model(a, b, op);
            load(a, b);
            run_op($sformatf("rand%0d_op%0d_a%0d_b%0d", i, op, a, b), op, er,
                   (op == 2) ? 16 : 2, 1'b0);
        end

        // Abort a multiply five cycles in.
        load(1234, 5678);
        run_op("pre_abort", 0, (1234 + 5678) % Q, 2, 1'b0);
        wr(5, 2);
        repeat (4) tick();
        rst_n = 1'b1;
        tick();
        chk("abort.busy", int'(uio_out[4]), 0);
        chk("abort.done", int'(uio_out[5]), 0);
        chk("abort.uo_out", int'(uo_out), 8'h00);
        chk("abort.uio_out", int'(uio_out), 8'h40);
        rst_n = 1'b0;
        tick();
        chk("abort.still_idle", int'(uio_out), 8'h40);

        // Reset wins over a simultaneous start strobe.
        load(7, 9);
        rst_n  = 1'b1;
        uio_in = 8'b0000_1011;
        ui_in  = 8'h00;
        tick();
        uio_in = 8'h00;
        rst_n  = 1'b0;
        chk("rst_prio.uio_out", int'(uio_out), 8'h40);
        tick();
        chk("rst_prio.no_busy", int'(uio_out[4]), 0);
        run_op("rst_prio.ops_cleared", 0, 0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_falcon.md
TT_UM_FALCON -- requirements
Module: tt_um_falcon

Interface
REQ-001 SHALL provide a single clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous reset, active-high (1 = reset), sampled on clk rising edge; name kept for harness compatibility.
REQ-004 Port: ena  input  1  design-select; ignored, block operates regardless.
REQ-005 Port: ui_in  input  8  data byte for operand loads and command arguments.
REQ-006 Port: uio_in  input  8  [0] write strobe, [3:1] command code, [7:4] unused.
REQ-007 Port: uo_out  output  8  selected result byte.
REQ-008 Port: uio_out  output  8  [4] busy, [5] done, [6] zero (result==0), [7] and [3:0] driven 0.
REQ-009 Port: uio_oe  output  8  constant 8'hF0.
REQ-010 Parameter: Q, default 12289, modulus (Falcon q); values are 14-bit unsigned.

Function
REQ-011 Registers SHALL be: A[13:0], B[13:0], R[13:0] result, op[1:0], sel (output byte select), busy, done, cycle counter.
REQ-012 Write SHALL occur on an edge where uio_in[0]=1, busy=0 and reset inactive; all writes while busy=1 are ignored entirely.
REQ-013 Command 001 SHALL load A[7:0]=ui_in; 010 A[13:8]=ui_in[5:0]; 011 B[7:0]=ui_in; 100 B[13:8]=ui_in[5:0].
REQ-014 Command 101 SHALL start an operation with op=ui_in[1:0]: 00 R=(A+B) mod Q; 01 R=(A-B) mod Q (non-negative result); 10 R=(A*B) mod Q; 11 R=A mod Q.
REQ-015 Command 110 SHALL set sel=ui_in[0]; commands 000 and 111 SHALL be no-ops.
REQ-016 A and B SHALL be treated as unsigned integers 0..16383 and may exceed Q; R SHALL always be in 0..Q-1.
REQ-017 Latency L SHALL be 2 cycles for ops 00/01/11 and 16 cycles for op 10 (sequential shift-add multiply with per-step modular reduction).
REQ-018 busy SHALL be 1 for exactly L cycles following the start edge; on the edge where busy falls, R is updated and done set to 1.
REQ-019 done SHALL stay 1 until the next accepted start, which clears it on the start edge.
REQ-020 R SHALL hold its previous value throughout busy; A/B changes after start are impossible (writes blocked).
REQ-021 uo_out SHALL be R[7:0] when sel=0 and {2'b00,R[13:8]} when sel=1, combinationally from registers.
REQ-022 zero SHALL be combinational (R==0).

Reset
REQ-023 Reset SHALL clear A, B, R, op, sel, busy, done, counter to 0, giving uo_out=0x00, uio_out=0x40, uio_oe=0xF0.
REQ-024 Reset asserted mid-operation SHALL abort it: busy=0, done=0, R=0 on the next edge; no partial result is retained.
REQ-025 Reset SHALL take priority over any simultaneous write strobe.

Verification
REQ-026 Reset 2 cycles -> uo_out=0x00, uio_out=0x40, uio_oe=0xF0.
REQ-027 A=12288, B=5, op add -> busy 2 cycles, done=1, R=4 (uo_out 0x04, sel=1 -> 0x00).
REQ-028 A=3, B=10, op sub -> R=12282 (low 0xFA, high 0x2F).
REQ-029 A=1234, B=5678, op mul -> busy exactly 16 cycles, R=1922 (low 0x82, high 0x07); start and load strobes during busy ignored.
REQ-030 A=12288, B=12288, op mul -> R=1; then A=16383, op reduce -> R=4094 (low 0xFE, high 0x0F).
REQ-031 Reset asserted 5 cycles into a mul -> next cycle busy=0, done=0, uo_out=0x00, uio_out=0x40.
